// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared pipeline constants and register-index type
package reg_scoreboard_pkg;
    localparam int NREG     = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 2;
    localparam int MAX_PEND = (1 << CNT_W) - 1;
    typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback/flush bundle between pipeline and scoreboard
interface reg_scoreboard_if #(parameter int NREG = reg_scoreboard_pkg::NREG);
    import reg_scoreboard_pkg::*;
    logic            issue_valid;
    logic            issue_wen;
    reg_idx_t        issue_rd;
    reg_idx_t        rs1;
    reg_idx_t        rs2;
    logic            use_rs1;
    logic            use_rs2;
    logic            wb_valid;
    reg_idx_t        wb_rd;
    logic            flush;
    logic            stall;
    logic [NREG-1:0] busy_vec;
    logic            err;
    modport master (
        output issue_valid, issue_wen, issue_rd, rs1, rs2, use_rs1, use_rs2, wb_valid, wb_rd, flush,
        input  stall, busy_vec, err
    );
    modport slave (
        input  issue_valid, issue_wen, issue_rd, rs1, rs2, use_rs1, use_rs2, wb_valid, wb_rd, flush,
        output stall, busy_vec, err
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: saturating pending-write counter with clear and underflow detect
module sb_counter #(
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    import reg_scoreboard_pkg::*;
    assign underflow = dec & !clr & (cnt == '0);
    // clear wins; simultaneous inc and dec cancel; never wrap at either end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !dec && cnt != '1)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracking with RAW/overflow stall
module reg_scoreboard #(
    parameter int NREG  = reg_scoreboard_pkg::NREG,
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);
    import reg_scoreboard_pkg::*;
    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    logic [CNT_W-1:0] pend [NREG];
    logic [NREG-1:0]  underflow;
    logic             stall;
    logic             acc_issue;
    logic             acc_wb;
    logic             err;
    assign pend[0]      = '0;
    assign underflow[0] = 1'b0;
    assign acc_issue    = sb.issue_valid & sb.issue_wen & (sb.issue_rd != '0) & !stall & !sb.flush;
    assign acc_wb       = sb.wb_valid & (sb.wb_rd != '0) & !sb.flush;
    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (acc_issue && sb.issue_rd == reg_idx_t'(i)),
            .dec       (acc_wb && sb.wb_rd == reg_idx_t'(i)),
            .clr       (sb.flush),
            .cnt       (pend[i]),
            .underflow (underflow[i])
        );
    end
    // hold decode on a busy source or when the destination counter is full
    always_comb begin
        stall = sb.issue_valid & ((sb.use_rs1 & (pend[sb.rs1] != '0)) |
                                  (sb.use_rs2 & (pend[sb.rs2] != '0)) |
                                  (sb.issue_wen & (sb.issue_rd != '0) & (pend[sb.issue_rd] == PEND_MAX)));
    end
    // busy flags come straight from counter state
    always_comb begin
        sb.busy_vec = '0;
        for (int k = 0; k < NREG; k++)
            sb.busy_vec[k] = (pend[k] != '0);
    end
    // sticky error on any writeback to a register with nothing pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (|underflow)
            err <= 1'b1;
    end
    assign sb.stall = stall;
    assign sb.err   = err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed stimulus with queued expectations checked by a monitor
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared   = 0;
    int mismatched = 0;
    typedef struct {
        string       name;
        logic        stall;
        logic [31:0] busy;
        logic        err;
    } exp_t;
    exp_t q[$];
    reg_scoreboard_if bus ();
    reg_scoreboard dut (.clk(clk), .rst(rst), .sb(bus));
    always #5 clk = ~clk;
    task automatic step(input string n, input logic r, input logic iv, input logic wen,
                        input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic wv,
                        input logic [4:0] wrd, input logic fl, input logic es,
                        input logic [31:0] eb, input logic ee);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.issue_valid = iv;
        bus.issue_wen   = wen;
        bus.issue_rd    = rd;
        bus.rs1         = r1;
        bus.use_rs1     = u1;
        bus.rs2         = r2;
        bus.use_rs2     = u2;
        bus.wb_valid    = wv;
        bus.wb_rd       = wrd;
        bus.flush       = fl;
        e.name  = n;
        e.stall = es;
        e.busy  = eb;
        e.err   = ee;
        q.push_back(e);
    endtask
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                compared++;
                if (bus.stall !== e.stall || bus.busy_vec !== e.busy || bus.err !== e.err) begin
                    mismatched++;
                    $display("FAIL %s: got stall=%b busy=%h err=%b, want stall=%b busy=%h err=%b",
                             e.name, bus.stall, bus.busy_vec, bus.err, e.stall, e.busy, e.err);
                end
            end
        end
    end
    initial begin
        bus.issue_valid = 0; bus.issue_wen = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
        bus.use_rs1 = 0; bus.use_rs2 = 0; bus.wb_valid = 0; bus.wb_rd = 0; bus.flush = 0;
        //     name            rst iv wen rd  rs1 u1 rs2 u2 wv wrd fl  stall busy        err
        step("reset_hold",     1, 1, 1,  5,  5,  1, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("reset_release",  0, 0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("issue5",         0, 1, 1,  5,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("raw5_stall",     0, 1, 0,  0,  5,  1, 0,  0, 0, 0,  0,  1,   32'h20,     0);
        step("raw5_wb_nobyp",  0, 1, 0,  0,  5,  1, 0,  0, 1, 5,  0,  1,   32'h20,     0);
        step("raw5_release",   0, 1, 0,  0,  5,  1, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("issue7_a",       0, 1, 1,  7,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("issue7_b",       0, 1, 1,  7,  0,  0, 0,  0, 0, 0,  0,  0,   32'h80,     0);
        step("issue7_c",       0, 1, 1,  7,  0,  0, 0,  0, 0, 0,  0,  0,   32'h80,     0);
        step("issue7_full",    0, 1, 1,  7,  0,  0, 0,  0, 0, 0,  0,  1,   32'h80,     0);
        step("issue7_full_wb", 0, 1, 1,  7,  0,  0, 0,  0, 1, 7,  0,  1,   32'h80,     0);
        step("issue7_retry",   0, 1, 1,  7,  0,  0, 0,  0, 0, 0,  0,  0,   32'h80,     0);
        step("issue9_wb7",     0, 1, 1,  9,  0,  0, 0,  0, 1, 7,  0,  0,   32'h80,     0);
        step("issue9_wb9",     0, 1, 1,  9,  0,  0, 0,  0, 1, 9,  0,  0,   32'h280,    0);
        step("same_cycle_9",   0, 0, 0,  0,  0,  0, 0,  0, 1, 7,  0,  0,   32'h280,    0);
        step("drain7",         0, 0, 0,  0,  0,  0, 0,  0, 1, 7,  0,  0,   32'h280,    0);
        step("drain9",         0, 0, 0,  0,  0,  0, 0,  0, 1, 9,  0,  0,   32'h200,    0);
        step("issue_rd0",      0, 1, 1,  0,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("src0_nostall",   0, 1, 0,  0,  0,  1, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("wb3_underflow",  0, 0, 0,  0,  0,  0, 0,  0, 1, 3,  0,  0,   32'h0,      0);
        step("err_set",        0, 0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      1);
        step("err_sticky",     0, 1, 1,  2,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      1);
        step("issue4",         0, 1, 1,  4,  0,  0, 0,  0, 0, 0,  0,  0,   32'h4,      1);
        step("issue6",         0, 1, 1,  6,  0,  0, 0,  0, 0, 0,  0,  0,   32'h14,     1);
        step("flush_issue8",   0, 1, 1,  8,  0,  0, 0,  0, 0, 0,  1,  0,   32'h54,     1);
        step("after_flush",    0, 1, 1, 10,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      1);
        step("pend10",         0, 0, 0,  0,  0,  0, 0,  0, 0, 0,  0,  0,   32'h400,    1);
        step("async_reset",    1, 1, 1, 10, 10,  1, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("post_reset",     0, 1, 1, 11,  0,  0, 0,  0, 0, 0,  0,  0,   32'h0,      0);
        step("rs2_raw11",      0, 1, 0,  0,  0,  0, 11, 1, 0, 0,  0,  1,   32'h800,    0);
        step("rs1_unused11",   0, 1, 0,  0, 11,  0, 0,  1, 0, 0,  0,  0,   32'h800,    0);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; index width is 5.
REQ-002 Parameter CNT_W, default 2, per-register pending-counter width; MAX_PEND = 2^CNT_W-1 = 3.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port issue_valid  in  1  decode stage presents an instruction.
REQ-006 Port issue_wen  in  1  presented instruction writes a destination register.
REQ-007 Port issue_rd  in  5  destination register index.
REQ-008 Port rs1, rs2  in  5 each  source register indices presented to the register-file read ports.
REQ-009 Port use_rs1, use_rs2  in  1 each  instruction actually consumes that source.
REQ-010 Port wb_valid  in  1  writeback commits a register write this cycle (same strobe as register-file write enable).
REQ-011 Port wb_rd  in  5  writeback destination index.
REQ-012 Port flush  in  1  pipeline flush; discards all in-flight writes.
REQ-013 Port stall  out  1  decode must hold; instruction not accepted.
REQ-014 Port busy_vec  out  NREG  bit i = register i has >=1 pending write.
REQ-015 Port err  out  1  sticky protocol-error flag.

Function
REQ-016 One CNT_W-bit pending counter per register; register 0 has no counter and reads as 0 permanently.
REQ-017 Accepted issue = issue_valid & issue_wen & (issue_rd != 0) & !stall & !flush.
REQ-018 Accepted writeback = wb_valid & (wb_rd != 0) & !flush.
REQ-019 Accepted issue to register r increments pend[r] by 1 at the next edge.
REQ-020 Accepted writeback to register r with pend[r] > 0 decrements pend[r] by 1 at the next edge.
REQ-021 Accepted issue and accepted writeback to the same r in the same cycle leave pend[r] unchanged.
REQ-022 Accepted writeback with pend[r] == 0 leaves the counter at 0 and sets err at the next edge.
REQ-023 stall is combinational: issue_valid & ((use_rs1 & pend[rs1]!=0) | (use_rs2 & pend[rs2]!=0) | (issue_wen & issue_rd!=0 & pend[issue_rd]==MAX_PEND)).
REQ-024 There is no same-cycle writeback bypass; a source whose last pending write commits in cycle N stalls in cycle N and is released in cycle N+1.
REQ-025 A source of index 0 never causes a stall.
REQ-026 flush clears all counters to 0 at the next edge and takes priority over issue and writeback in the same cycle; err is unaffected.
REQ-027 busy_vec[i] = (pend[i] != 0), driven from registered state only; busy_vec[0] = 0.
REQ-028 Counters never wrap; increment at MAX_PEND is blocked by REQ-023.

Reset
REQ-029 rst asserted forces all counters to 0 and err to 0 immediately, independent of clk.
REQ-030 During reset: busy_vec = 0; stall = 0 for any inputs.
REQ-031 Reset mid-operation discards all pending state; the first edge after deassertion processes inputs normally.

Structure
REQ-032 NREG, CNT_W, MAX_PEND and the register-index type live in the shared pipeline package.
REQ-033 One sub-module, sb_counter: single saturating up/down counter with inc, dec, clr, underflow output; instantiated NREG-1 times.

Verification
REQ-034 Issue rd=5, next cycle rs1=5 use_rs1=1 -> stall=1, busy_vec[5]=1; wb_rd=5 -> stall stays 1 that cycle, 0 the cycle after.
REQ-035 Three accepted issues to rd=7, fourth issue to rd=7 -> stall=1, pend[7] holds 3; one wb to 7 -> fourth issue accepted next cycle.
REQ-036 Issue rd=9 and wb rd=9 same cycle with pend[9]=1 -> pend[9] stays 1, busy_vec[9]=1.
REQ-037 Issue rd=0, then rs1=0 use_rs1=1 -> stall=0, busy_vec=0; wb_rd=3 with pend[3]=0 -> err=1 and stays 1.
REQ-038 Pending on regs 2,4,6, assert flush with simultaneous issue rd=8 -> busy_vec=0 next cycle, err unchanged.
REQ-039 Pending on reg 10, assert rst between clock edges -> busy_vec=0 and err=0 before the next edge.
